// File: rtl/dff_shift_bank_if.sv
// Control, data and status bundle for dff_shift_bank.
// The master side drives controls and reads state; the slave side is the register bank.
interface dff_shift_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   en;
    logic                   clr;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       d_up;
    logic [WIDTH-1:0]       d_dn;
    logic [DEPTH*WIDTH-1:0] load_data;
    logic [DEPTH*WIDTH-1:0] q_all;
    logic [WIDTH-1:0]       q_head;
    logic [WIDTH-1:0]       q_tail;
    logic [CW-1:0]          fill_count;
    logic                   full;

    modport master (
        output en, clr, mode, d_up, d_dn, load_data,
        input  q_all, q_head, q_tail, fill_count, full
    );

    modport slave (
        input  en, clr, mode, d_up, d_dn, load_data,
        output q_all, q_head, q_tail, fill_count, full
    );
endinterface

// File: rtl/dff_shift_bank.sv
// Bank of DEPTH x WIDTH registers: bidirectional shift, hold, parallel load and clear,
// with a saturating count of words inserted since the last clear.
module dff_shift_bank #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    dff_shift_bank_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DN   = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Stage i occupies bits [i*WIDTH +: WIDTH], so shifts are plain slice concatenations.
    logic [DEPTH*WIDTH-1:0] bank;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            bank <= '0;
            cnt  <= '0;
        end else if (bus.en) begin
            if (bus.clr) begin
                bank <= '0;
                cnt  <= '0;
            end else begin
                case (bus.mode)
                    MODE_UP: begin
                        bank <= {bank[(DEPTH-1)*WIDTH-1:0], bus.d_up};
                        if (cnt != FULL_COUNT)
                            cnt <= cnt + 1'b1;
                    end
                    MODE_DN: begin
                        bank <= {bus.d_dn, bank[DEPTH*WIDTH-1:WIDTH]};
                        if (cnt != FULL_COUNT)
                            cnt <= cnt + 1'b1;
                    end
                    MODE_LOAD: begin
                        bank <= bus.load_data;
                        cnt  <= FULL_COUNT;
                    end
                    // Hold, and any unknown mode, leaves state untouched so X cannot leak in.
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.q_all      = bank;
    assign bus.q_head     = bank[WIDTH-1:0];
    assign bus.q_tail     = bank[DEPTH*WIDTH-1 -: WIDTH];
    assign bus.fill_count = cnt;
    assign bus.full       = (cnt == FULL_COUNT);

endmodule
